dmem_port_arbiter: RTL and testbench

- Shares the single-port, synchronous-read data memory between two requesters:
  - the pipeline memory stage (CPU port);
  - a streaming pixel/RGB reader (VID port) that scans image data for display output.
- The CPU has fixed priority.
- A starvation counter forces periodic VID grants. On those cycles `cpu_stall` is raised so the pipeline holds its memory stage.
- Sits between the memory-stage datapath, the display reader and the data RAM macro.

---
 rtl/dmem_port_arbiter.sv | 108 ++++++++++
 tb/tb_dmem_port_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares one single-port, synchronous-read data RAM between the pipeline
//   memory stage (CPU port, fixed priority) and a streaming display reader
//   (VID port). A starvation counter forces a VID grant after STARVE_MAX
//   consecutive denied VID cycles. On that cycle cpu_stall is raised.
//
// Ports
//   clk, rst                   clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata      CPU access request
//   cpu_rdata, cpu_stall       CPU read data (1 cycle after accept), hold
//   vid_req/addr               reader read request
//   vid_gnt, vid_rvalid/rdata  reader accept (comb), read return
//   mem_en/we/addr/wdata       RAM request
//   mem_rdata                  RAM read data, 1 cycle after a read
module dmem_port_arbiter #(
  parameter int DATA_W     = 18,
  parameter int ADDR_W     = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, CPU, VID, VID_FORCED} owner_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_CPU, TAG_VID} tag_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  owner_t            owner_q, owner_d;
  tag_t              rd_tag_q, tag_d;
  logic [3:0]        starve_q, starve_d;
  logic [DATA_W-1:0] hold_q;
  logic              forced, gnt_cpu, gnt_vid;

  always_comb begin
    // The owner check never changes behaviour (starve_q is cleared by the
    // forced grant), it just makes "no two forced grants in a row" explicit.
    forced  = vid_req && (starve_q >= STARVE_LIM) && (owner_q != VID_FORCED);
    gnt_vid = forced || (vid_req && !cpu_req);
    gnt_cpu = cpu_req && !forced;

    if (forced)       owner_d = VID_FORCED;
    else if (cpu_req) owner_d = CPU;
    else if (vid_req) owner_d = VID;
    else              owner_d = IDLE;

    if (!vid_req || gnt_vid)  starve_d = 4'd0;
    else if (starve_q == 4'hf) starve_d = 4'hf;
    else                       starve_d = starve_q + 4'd1;

    if (gnt_cpu && !cpu_we) tag_d = TAG_CPU;
    else if (gnt_vid)       tag_d = TAG_VID;
    else                    tag_d = TAG_NONE;
  end

  // Every output is forced low while reset is held, whatever the inputs.
  always_comb begin
    cpu_stall  = rst && cpu_req && forced;
    vid_gnt    = rst && gnt_vid;
    mem_en     = rst && (gnt_cpu || gnt_vid);
    mem_we     = rst && gnt_cpu && cpu_we;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (rst && gnt_cpu) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (rst && gnt_vid) begin
      mem_addr  = vid_addr;
    end
    vid_rvalid = rst && (rd_tag_q == TAG_VID);
    vid_rdata  = vid_rvalid ? mem_rdata : '0;
    // Bypass the returning word so CPU data is visible one cycle after the
    // accepted read, and hold it in hold_q afterwards.
    cpu_rdata  = '0;
    if (rst) cpu_rdata = (rd_tag_q == TAG_CPU) ? mem_rdata : hold_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q  <= IDLE;
      starve_q <= 4'd0;
      rd_tag_q <= TAG_NONE;
      hold_q   <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
      rd_tag_q <= tag_d;
      if (rd_tag_q == TAG_CPU) hold_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: RAM model, per-cycle reference model/checker,
// directed sequences with literal expectations and randomized traffic.
module tb_dmem_port_arbiter;
  localparam int DW = 18, AW = 10, SM = 4;

  logic          clk = 1'b0, rst = 1'b0;
  logic          cpu_req = 0, cpu_we = 0, vid_req = 0;
  logic [AW-1:0] cpu_addr = '0, vid_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, mem_rdata = '0;
  logic [DW-1:0] cpu_rdata, vid_rdata, mem_wdata;
  logic          cpu_stall, vid_gnt, vid_rvalid, mem_en, mem_we;
  logic [AW-1:0] mem_addr;

  int n_chk = 0, n_fail = 0;

  dmem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  // Synchronous single-port RAM
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end

  // Reference model: pending-read owner, its data, CPU hold, starvation count
  int            m_starve;
  int            m_tag;      // 0 none, 1 cpu, 2 vid
  logic [DW-1:0] m_rd_data, m_hold;

  logic          e_forced, e_gcpu, e_gvid;
  always @* begin
    e_forced = vid_req && (m_starve >= SM);
    e_gvid   = e_forced || (vid_req && !cpu_req);
    e_gcpu   = cpu_req && !e_forced;
  end

  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_starve <= 0; m_tag <= 0; m_rd_data <= '0; m_hold <= '0;
    end else begin
      if (m_tag == 1) m_hold <= m_rd_data;
      m_tag     <= (e_gcpu && !cpu_we) ? 1 : (e_gvid ? 2 : 0);
      m_rd_data <= e_gcpu ? ram[cpu_addr] : ram[vid_addr];
      if (!vid_req || e_gvid) m_starve <= 0;
      else m_starve <= (m_starve + 1 > 15) ? 15 : m_starve + 1;
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic [AW-1:0] ea;
    ea = e_gcpu ? cpu_addr : (e_gvid ? vid_addr : '0);
    chk("cpu_stall", 32'(cpu_stall), 32'(rst && cpu_req && e_forced));
    chk("vid_gnt",   32'(vid_gnt),   32'(rst && e_gvid));
    chk("mem_en",    32'(mem_en),    32'(rst && (e_gcpu || e_gvid)));
    chk("mem_we",    32'(mem_we),    32'(rst && e_gcpu && cpu_we));
    chk("mem_addr",  32'(mem_addr),  rst ? 32'(ea) : 32'd0);
    chk("mem_wdata", 32'(mem_wdata), (rst && e_gcpu) ? 32'(cpu_wdata) : 32'd0);
    chk("vid_rvalid", 32'(vid_rvalid), 32'(rst && m_tag == 2));
    chk("vid_rdata", 32'(vid_rdata), (rst && m_tag == 2) ? 32'(m_rd_data) : 32'd0);
    chk("cpu_rdata", 32'(cpu_rdata),
        !rst ? 32'd0 : (m_tag == 1 ? 32'(m_rd_data) : 32'(m_hold)));
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic idle(); cpu_req = 0; cpu_we = 0; vid_req = 0; endtask

  initial begin
    bit hold;
    for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(i * 7);

    // Reset held: outputs low regardless of requests
    cpu_req = 1; vid_req = 1; cpu_we = 1; cpu_addr = 10'h3; vid_addr = 10'h5;
    #4;
    chk("rst_stall", 32'(cpu_stall), 0);
    chk("rst_vgnt", 32'(vid_gnt), 0);
    chk("rst_men", 32'(mem_en), 0);
    tick(); idle(); rst = 1;

    // CPU write then read back
    tick();
    cpu_req = 1; cpu_we = 1; cpu_addr = 10'h010; cpu_wdata = 18'h2AAAA; #3;
    chk("wr_we", 32'(mem_we), 1); chk("wr_stall", 32'(cpu_stall), 0);
    tick(); cpu_we = 0; #3;
    chk("rd_we", 32'(mem_we), 0); chk("rd_stall", 32'(cpu_stall), 0);
    tick(); idle(); #3;
    chk("rd_data", 32'(cpu_rdata), 32'h2AAAA);

    // VID-only stream
    for (int i = 0; i < 4; i++) ram[i] = DW'(18'h100 + i);
    for (int i = 0; i <= 4; i++) begin
      tick();
      vid_req = (i < 4); vid_addr = AW'(i); #3;
      if (i < 4) chk("vid_gnt_seq", 32'(vid_gnt), 1);
      if (i >= 1) begin
        chk("vid_rv_seq", 32'(vid_rvalid), 1);
        chk("vid_rd_seq", 32'(vid_rdata), 32'h100 + 32'(i - 1));
      end
    end

    // Contention: forced VID every 5th cycle
    tick(); idle(); tick();
    cpu_req = 1; vid_req = 1; cpu_addr = 10'h20;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) tick();
      #3;
      chk("cont_starve", 32'(dut.starve_q), 32'(c % 5));
      chk("cont_vgnt", 32'(vid_gnt), 32'(c % 5 == 4));
      chk("cont_stall", 32'(cpu_stall), 32'(c % 5 == 4));
    end

    // VID drop at cycle 2 restarts the count
    tick(); idle(); tick(); cpu_req = 1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      vid_req = (c != 2); #3;
      if (c == 3) chk("drop_starve", 32'(dut.starve_q), 0);
      if (c >= 3) chk("drop_vgnt", 32'(vid_gnt), 32'(c == 7));
    end

    // Reset while a VID read is in flight
    tick(); idle(); tick();
    vid_req = 1; vid_addr = 10'h2; #3;
    chk("mid_gnt", 32'(vid_gnt), 1);
    #3 rst = 0; #1;
    chk("mid_rv_rst", 32'(vid_rvalid), 0);
    tick(); vid_req = 0; #3;
    chk("mid_rv_after", 32'(vid_rvalid), 0);
    tick(); rst = 1; #3;
    chk("mid_starve", 32'(dut.starve_q), 0);
    chk("mid_cpurd", 32'(cpu_rdata), 0);
    chk("mid_rv", 32'(vid_rvalid), 0);

    // No requests: CPU data holds
    tick(); cpu_req = 1; cpu_addr = 10'h010;
    tick(); idle();
    for (int c = 0; c < 3; c++) begin
      tick(); #3;
      chk("idle_men", 32'(mem_en), 0);
      chk("idle_hold", 32'(cpu_rdata), 32'h2AAAA);
    end

    // Randomized traffic; a stalled CPU request is held stable
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); hold = rst && cpu_req && e_forced;
      tick();
      rst = ($urandom_range(0, 299) != 0);
      if (!hold) begin
        cpu_req = ($urandom_range(0, 1) == 1); cpu_we = ($urandom_range(0, 2) == 0);
        cpu_addr = AW'($urandom_range(0, 15)); cpu_wdata = DW'($urandom);
      end
      vid_req = ($urandom_range(0, 9) < 7); vid_addr = AW'($urandom_range(0, 15));
    end
    tick(); rst = 1; idle(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
